// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the move sequencer and its per-axis trackers.
package move_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHUNK     = 2'd1,
        TRIGGER   = 2'd2,
        WAIT_DONE = 2'd3
    } move_sequencer_state_t;

    // Largest magnitude a signed step count of count_bits can carry symmetrically.
    function automatic int max_chunk(input int count_bits);
        return (1 << (count_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/move_sequencer_axis_tracker.sv
// One axis of the sequencer: committed position, remaining delta and the clamped chunk.
module seq_axis_tracker
    import move_sequencer_pkg::*;
#(
    parameter int POS_BITS   = 16,
    parameter int COUNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic signed [POS_BITS-1:0]   target_i,
    input  logic                         commit_i,
    input  logic                         clear_i,
    output logic signed [POS_BITS-1:0]   pos_o,
    output logic signed [COUNT_BITS-1:0] chunk_o,
    output logic                         chunk_zero_o
);

    localparam int REM_BITS = POS_BITS + 1;
    localparam int MAX_C    = max_chunk(COUNT_BITS);
    localparam logic signed [REM_BITS-1:0]   MAX_REM = REM_BITS'(MAX_C);
    localparam logic signed [REM_BITS-1:0]   MIN_REM = -MAX_REM;
    localparam logic signed [COUNT_BITS-1:0] MAX_CV  = COUNT_BITS'(MAX_C);
    localparam logic signed [COUNT_BITS-1:0] MIN_CV  = -MAX_CV;

    logic signed [POS_BITS-1:0] pos_q, pos_d;
    logic signed [REM_BITS-1:0] rem_q, rem_d;
    logic signed [REM_BITS-1:0] chunk_ext;

    // Symmetric clamp: the most negative count code is never produced.
    always_comb begin
        chunk_o = rem_q[COUNT_BITS-1:0];
        if (rem_q > MAX_REM) begin
            chunk_o = MAX_CV;
        end else if (rem_q < MIN_REM) begin
            chunk_o = MIN_CV;
        end
        chunk_zero_o = (chunk_o == '0);
        chunk_ext    = {{(REM_BITS-COUNT_BITS){chunk_o[COUNT_BITS-1]}}, chunk_o};
    end

    always_comb begin
        pos_d = pos_q;
        rem_d = rem_q;
        if (clear_i) begin
            pos_d = '0;
        end else if (load_i) begin
            rem_d = {target_i[POS_BITS-1], target_i} - {pos_q[POS_BITS-1], pos_q};
        end else if (commit_i) begin
            pos_d = pos_q + chunk_ext[POS_BITS-1:0];
            rem_d = rem_q - chunk_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
            rem_q <= '0;
        end else begin
            pos_q <= pos_d;
            rem_q <= rem_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/move_sequencer.sv
// Feeds absolute XY targets to the stepper as a series of bounded signed chunks.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int POS_BITS   = 16,
    parameter int COUNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic signed [POS_BITS-1:0]   cmd_x,
    input  logic signed [POS_BITS-1:0]   cmd_y,
    input  logic                         set_origin,
    output logic                         trigger,
    output logic signed [COUNT_BITS-1:0] num_steps_x,
    output logic signed [COUNT_BITS-1:0] num_steps_y,
    input  logic                         done,
    output logic signed [POS_BITS-1:0]   pos_x,
    output logic signed [POS_BITS-1:0]   pos_y,
    output logic                         busy,
    output move_sequencer_state_t        dbg_state
);

    // A target is taken on any clk where cmd_valid & cmd_ready & !set_origin;
    // cmd_ready depends only on state, never on cmd_valid.
    move_sequencer_state_t state_q, state_d;
    logic blank_q, blank_d;
    logic signed [COUNT_BITS-1:0] steps_x_q, steps_x_d, steps_y_q, steps_y_d;
    logic signed [COUNT_BITS-1:0] chunk_x, chunk_y;
    logic zero_x, zero_y;
    logic load, commit, clear;

    seq_axis_tracker #(.POS_BITS(POS_BITS), .COUNT_BITS(COUNT_BITS)) u_axis_x (
        .clk(clk), .reset(reset), .load_i(load), .target_i(cmd_x), .commit_i(commit),
        .clear_i(clear), .pos_o(pos_x), .chunk_o(chunk_x), .chunk_zero_o(zero_x)
    );

    seq_axis_tracker #(.POS_BITS(POS_BITS), .COUNT_BITS(COUNT_BITS)) u_axis_y (
        .clk(clk), .reset(reset), .load_i(load), .target_i(cmd_y), .commit_i(commit),
        .clear_i(clear), .pos_o(pos_y), .chunk_o(chunk_y), .chunk_zero_o(zero_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            blank_q   <= 1'b0;
            steps_x_q <= '0;
            steps_y_q <= '0;
        end else begin
            state_q   <= state_d;
            blank_q   <= blank_d;
            steps_x_q <= steps_x_d;
            steps_y_q <= steps_y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blank_d   = blank_q;
        steps_x_d = steps_x_q;
        steps_y_d = steps_y_q;
        case (state_q)
            IDLE: begin
                if (!set_origin && cmd_valid) state_d = CHUNK;
            end
            CHUNK: begin
                if (zero_x && zero_y) begin
                    state_d = IDLE;
                end else begin
                    state_d   = TRIGGER;
                    steps_x_d = chunk_x;
                    steps_y_d = chunk_y;
                end
            end
            TRIGGER: begin
                if (clk_en) begin
                    state_d = WAIT_DONE;
                    blank_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                // The stepper still shows done on the tick right after it sees trigger.
                if (blank_q) begin
                    if (clk_en) blank_d = 1'b0;
                end else if (done) begin
                    state_d = CHUNK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        trigger   = (state_q == TRIGGER);
        clear     = (state_q == IDLE) && set_origin;
        load      = (state_q == IDLE) && !set_origin && cmd_valid;
        commit    = (state_q == WAIT_DONE) && !blank_q && done;
    end

    assign num_steps_x = steps_x_q;
    assign num_steps_y = steps_y_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural stepper and chunk scoreboard.
module tb_move_sequencer;
    import move_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset, clk_en, cmd_valid, cmd_ready, set_origin, trigger, done, busy;
    logic signed [15:0] cmd_x, cmd_y, pos_x, pos_y;
    logic signed [7:0]  num_steps_x, num_steps_y;
    move_sequencer_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    int en_period = 4;
    int en_cnt = 0;
    int hi_ticks = 0;
    int trig_count = 0;
    int step_cnt = 0;
    logic trig_prev = 1'b0;
    logic pend = 1'b0;
    logic [15:0] held = '0;
    move_sequencer_state_t prev_state = IDLE;

    move_sequencer #(.POS_BITS(16), .COUNT_BITS(8)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y), .set_origin(set_origin),
        .trigger(trigger), .num_steps_x(num_steps_x), .num_steps_y(num_steps_y),
        .done(done), .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor, stepper model and tick generator. Runs on negedge; clk_en and
    // trig_prev still hold the values seen at the preceding posedge.
    always @(negedge clk) begin
        logic [15:0] e;
        int ax, ay;
        if (trig_prev && clk_en) hi_ticks++;
        if (trigger && !trig_prev) begin
            trig_count++;
            check("trig_after_chunk", int'(prev_state), int'(CHUNK));
            if (exp_q.size() == 0) begin
                check("unexpected_trigger", trig_count, 0);
            end else begin
                e = exp_q.pop_front();
                check("chunk_x", int'(num_steps_x), int'($signed(e[15:8])));
                check("chunk_y", int'(num_steps_y), int'($signed(e[7:0])));
            end
            held = {num_steps_x, num_steps_y};
            hi_ticks = 0;
        end
        if (trigger && trig_prev) check("steps_stable", int'({num_steps_x, num_steps_y}), int'(held));
        if (!trigger && trig_prev && !reset) check("trig_ticks", hi_ticks, 1);

        if (reset) begin
            done = 1'b1;
            pend = 1'b0;
            step_cnt = 0;
        end else if (clk_en) begin
            if (pend) begin
                done = 1'b0;
                pend = 1'b0;
            end else if (!done) begin
                if (step_cnt <= 1) done = 1'b1;
                else step_cnt--;
            end
            if (trig_prev) begin
                ax = int'(num_steps_x);
                ay = int'(num_steps_y);
                if (ax < 0) ax = -ax;
                if (ay < 0) ay = -ay;
                step_cnt = (ax > ay) ? ax : ay;
                pend = 1'b1;
            end
        end
        trig_prev = trigger;
        prev_state = dbg_state;

        en_cnt++;
        if (en_cnt >= en_period) begin
            en_cnt = 0;
            clk_en = 1'b1;
        end else begin
            clk_en = 1'b0;
        end
    end

    task automatic push_exp(input int x, input int y);
        exp_q.push_back({8'(x), 8'(y)});
    endtask

    task automatic send_cmd(input int x, input int y);
        int n;
        @(negedge clk);
        cmd_x = 16'(x);
        cmd_y = 16'(y);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x = 16'h7fff;
        cmd_y = 16'h7fff;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic check_pos(input int x, input int y);
        check("pos_x", int'(pos_x), x);
        check("pos_y", int'(pos_y), y);
        check("chunks_left", exp_q.size(), 0);
    endtask

    initial begin
        int base, n;
        reset = 1'b1;
        clk_en = 1'b0;
        done = 1'b1;
        cmd_valid = 1'b0;
        set_origin = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_trigger", int'(trigger), 0);
        check("rst_steps_x", int'(num_steps_x), 0);
        check("rst_steps_y", int'(num_steps_y), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        check_pos(0, 0);

        // Single small move
        push_exp(2, 3);
        send_cmd(2, 3);
        wait_idle();
        check_pos(2, 3);
        check("move1_cmd_ready", int'(cmd_ready), 1);

        // Origin alone
        @(negedge clk);
        set_origin = 1'b1;
        @(negedge clk);
        set_origin = 1'b0;
        check_pos(0, 0);

        // Long move split into three chunks
        push_exp(127, -10);
        push_exp(127, 0);
        push_exp(46, 0);
        send_cmd(300, -10);
        wait_idle();
        check_pos(300, -10);

        // Zero-delta command
        base = trig_count;
        send_cmd(300, -10);
        check("zero_in_chunk", int'(dbg_state), int'(CHUNK));
        check("zero_not_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("zero_ready_again", int'(cmd_ready), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_no_trigger", trig_count, base);

        // Sparse clk_en: trigger held until the tick
        en_period = 50;
        push_exp(10, 0);
        send_cmd(310, -10);
        wait_idle();
        check_pos(310, -10);
        check("hold_steps_x", int'(num_steps_x), 10);
        check("hold_steps_y", int'(num_steps_y), 0);
        en_period = 4;

        // Reset during the second chunk's wait
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_pos(0, 0);
        push_exp(127, -10);
        push_exp(127, 0);
        push_exp(46, 0);
        base = trig_count;
        send_cmd(300, -10);
        n = 0;
        while (!(trig_count >= base + 2 && dbg_state == WAIT_DONE) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("chunk2_wait", int'(dbg_state), int'(WAIT_DONE));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("abort_trigger", int'(trigger), 0);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_pos_x", int'(pos_x), 0);
        check("abort_pos_y", int'(pos_y), 0);
        reset = 1'b0;
        exp_q.delete();
        push_exp(5, 5);
        send_cmd(5, 5);
        wait_idle();
        check_pos(5, 5);

        // Negative clamp, then set_origin beats cmd_valid
        push_exp(-127, 45);
        push_exp(-78, 0);
        send_cmd(-200, 50);
        wait_idle();
        check_pos(-200, 50);
        @(negedge clk);
        set_origin = 1'b1;
        cmd_valid = 1'b1;
        cmd_x = 16'sd7;
        cmd_y = 16'sd7;
        @(posedge clk);
        #1;
        set_origin = 1'b0;
        cmd_valid = 1'b0;
        check("origin_state", int'(dbg_state), int'(IDLE));
        check("origin_busy", int'(busy), 0);
        check_pos(0, 0);
        push_exp(1, 1);
        send_cmd(1, 1);
        wait_idle();
        check_pos(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
